prbs_code_checker: RTL and testbench
====================================

# prbs_code_checker

Receive-side counterpart of the transmit source generator. Consumes the recovered serial code stream from the 2FSK demodulator, self-synchronises to the 8-bit source-word sequence, then checks every following bit against the predicted sequence. Reports lock status, per-bit error pulses, saturating bit and error counters, and each recovered word for BER measurement on the receiving board.

## Interface
Parameters:
- LOCK_WORDS, 4: consecutive error-free words in VERIFY needed to declare lock.
- UNLOCK_WORDS, 4: consecutive errored words in LOCKED needed to drop lock.
- CNT_W, 16: width of bit_cnt and err_cnt.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  bit strobe; code_in is sampled only when high.
- code_in  in  1  demodulated serial bit, MSB of each word first.
- clr_cnt  in  1  synchronous clear of bit_cnt and err_cnt.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched bit while LOCKED.
- word_out  out  8  last completed received word, MSB = first bit.
- word_valid  out  1  one-cycle pulse when word_out updates.
- bit_cnt  out  CNT_W  bits checked while LOCKED, saturating.
- err_cnt  out  CNT_W  mismatches while LOCKED, saturating.

## Operation
- Sequence law: after word W, the transmitter sends N = {W[6:0], W[7]^W[3]^W[2]^W[1]}, 8 bits MSB first, back to back. Power-up seed is 0xAA: 0xAA, 0x55, 0xAB, 0x57, ...
- A valid bit is any cycle with enable=1. A 3-bit position counter (0..7) advances on valid bits only.
- HUNT: shift valid bits into a capture register. On the 8th bit, pred <= next(captured word), good_cnt <= 0, go to VERIFY.
- VERIFY: compare each valid bit with pred[7-pos]. On mismatch, go to HUNT with pos reset to 0 and the bit discarded. On a word completed without error: good_cnt+1, pred <= next(pred). When good_cnt reaches LOCK_WORDS, go to LOCKED.
- LOCKED (flywheel): compare each valid bit with pred. pred always advances from pred, never from received data, so errors do not propagate. Per valid bit: bit_cnt+1. On mismatch: err_cnt+1 and err_pulse. A word with at least one mismatch increments bad_cnt; an error-free word clears it. When bad_cnt reaches UNLOCK_WORDS, go to HUNT at the next word boundary with pos=0.
- word_out/word_valid are produced in all states, from received bits.
- Counters saturate at all-ones and never wrap.
- clr_cnt: sets both counters to 0 on the next edge. If clr_cnt and a counted bit or error coincide, clear wins and the result is 0.
- enable low: hold all state, with no pulses; pos is not reset. Gaps of any length are tolerated.

## Timing
- Reset values: locked=0, err_pulse=0, word_valid=0, word_out=0x00, bit_cnt=0, err_cnt=0, state=HUNT, pos=0, pred=0x00.
- err_pulse and word_valid are asserted the cycle after the sampling edge of the relevant bit. word_valid follows the 8th bit of a word.
- locked rises in the cycle after the last bit of the LOCK_WORDS-th verified word. It falls in the cycle after the last bit of the UNLOCK_WORDS-th bad word.
- Minimum acquisition with clean data and the default parameter: 8 + 8*LOCK_WORDS = 40 valid bits.
- Reset mid-operation: immediate return to reset values. Reacquisition starts with the next valid bit.

## Structure
- Shared package prbs_pkg:
  - state enum {HUNT, VERIFY, LOCKED};
  - function next_word(w) implementing the feedback law;
  - SEED = 8'hAA for benches.
- The transmitter and this checker both use next_word so the feedback law exists once.
- One sub-module, prbs_word_predictor, owns pred and pos: load, advance on valid bit, word-end strobe, expected-bit output. The top holds the FSM, counters and outputs.

## Test plan
- Clean stream from seed 0xAA, enable=1 continuously: locked rises after bit 40; word_out sequence is 0xAA, 0x55, 0xAB, 0x57, ...; after 800 more bits, bit_cnt=800 and err_cnt=0.
- Locked, then invert one bit in each of 3 separate words: exactly 3 err_pulse, err_cnt=3, locked stays 1.
- Locked, then 4 consecutive words each with 1 flipped bit: locked falls after the 4th. A clean stream then relocks after 40 bits, and err_cnt=4 is retained.
- Start mid-stream (arbitrary bit offset) with enable toggling 1/0 every cycle: lock still achieved after 40 valid bits.
- Bit flipped during VERIFY at word 2: return to HUNT, and locked is not asserted before a full 40 further clean bits.
- err_cnt forced near saturation with CNT_W=4: holds at 15. Assert clr_cnt together with an error: both counters read 0. Assert rst_n low mid-word: all outputs at reset values immediately.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions for the transmit source generator and the receive
// code checker.
//   state_t   : checker acquisition states
//   SEED      : power-up word of the transmit sequence
//   next_word : word-to-word feedback law, the single definition of the sequence
package prbs_pkg;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [7:0] SEED = 8'hAA;

  // Shift left by one and append W[7]^W[3]^W[2]^W[1] as the new LSB.
  function automatic logic [7:0] next_word(input logic [7:0] w);
    return {w[6:0], w[7] ^ w[3] ^ w[2] ^ w[1]};
  endfunction

endpackage

// File: rtl/prbs_code_checker_if.sv
// Bit-stream and status bundle of the PRBS code checker.
//   master : bit source / status consumer (drives enable, code_in, clr_cnt)
//   slave  : the checker (drives lock status, pulses, word and counters)
interface prbs_code_checker_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             code_in;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [7:0]       word_out;
  logic             word_valid;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output enable, code_in, clr_cnt,
    input  locked, err_pulse, word_out, word_valid, bit_cnt, err_cnt
  );

  modport slave (
    input  enable, code_in, clr_cnt,
    output locked, err_pulse, word_out, word_valid, bit_cnt, err_cnt
  );
endinterface

// File: rtl/prbs_word_predictor.sv
// Predicted-word register and bit position within the word.
//   advance   : valid bit strobe, moves pos forward (wraps 7 -> 0)
//   clr_pos   : force pos back to 0 (takes priority over advance)
//   load      : load pred with load_word
//   step      : advance pred to next_word(pred)
//   exp_bit   : bit of pred expected at the current position (MSB first)
//   word_end  : the current valid bit is the 8th bit of a word
module prbs_word_predictor
  import prbs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  input  logic       clr_pos,
  input  logic       load,
  input  logic [7:0] load_word,
  input  logic       step,
  output logic       exp_bit,
  output logic       word_end
);

  logic [7:0] pred;
  logic [2:0] pos;

  assign exp_bit  = pred[3'd7 - pos];
  assign word_end = advance && (pos == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= 3'd0;
      pred <= 8'h00;
    end else begin
      if (clr_pos)
        pos <= 3'd0;
      else if (advance)
        pos <= pos + 3'd1;

      if (load)
        pred <= load_word;
      else if (step)
        pred <= next_word(pred);
    end
  end

endmodule

// File: rtl/prbs_code_checker.sv
// Receive-side PRBS checker: self-synchronises to the 8-bit word sequence,
// then checks every bit against the flywheel prediction.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.enable / bus.code_in : bit strobe and demodulated bit (MSB first)
//   bus.clr_cnt   : synchronous clear of both counters (wins over counting)
//   bus.locked    : high while in LOCKED
//   bus.err_pulse : one-cycle pulse per mismatched bit while LOCKED
//   bus.word_out / bus.word_valid : last completed received word and its strobe
//   bus.bit_cnt / bus.err_cnt     : saturating checked-bit and error counters
module prbs_code_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_WORDS   = 4,
  parameter int UNLOCK_WORDS = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  prbs_code_checker_if.slave bus
);

  localparam int GW = $clog2(LOCK_WORDS + 1);
  localparam int BW = $clog2(UNLOCK_WORDS + 1);

  state_t           state;
  logic [GW-1:0]    good_cnt;
  logic [BW-1:0]    bad_cnt;
  logic             word_bad;
  logic [7:0]       rx_sr;
  logic             locked_q;
  logic             err_pulse_q;
  logic [7:0]       word_out_q;
  logic             word_valid_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic       valid;
  logic       mism;
  logic       exp_bit;
  logic       word_end;
  logic       pred_load;
  logic       pred_step;
  logic       pos_clr;
  logic [7:0] rx_word;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign valid   = bus.enable;
  assign mism    = valid && (bus.code_in != exp_bit);
  assign rx_word = {rx_sr[6:0], bus.code_in};

  // In LOCKED the prediction free-runs from itself, so received errors never
  // corrupt it; only HUNT seeds it from received data.
  assign pred_load = (state == HUNT) && word_end;
  assign pred_step = word_end && (((state == VERIFY) && !mism) || (state == LOCKED));
  // A mismatch in VERIFY discards the bit and restarts word alignment.
  assign pos_clr   = (state == VERIFY) && mism;

  prbs_word_predictor u_pred (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (valid),
    .clr_pos   (pos_clr),
    .load      (pred_load),
    .load_word (next_word(rx_word)),
    .step      (pred_step),
    .exp_bit   (exp_bit),
    .word_end  (word_end)
  );

  always_ff @(posedge clk) begin
    if (valid)
      rx_sr <= rx_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      good_cnt     <= '0;
      bad_cnt      <= '0;
      word_bad     <= 1'b0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      word_out_q   <= 8'h00;
      word_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      err_pulse_q  <= (state == LOCKED) && mism;
      word_valid_q <= 1'b0;

      if (word_end && !pos_clr) begin
        word_out_q   <= rx_word;
        word_valid_q <= 1'b1;
      end

      case (state)
        HUNT: begin
          if (word_end) begin
            state    <= VERIFY;
            good_cnt <= '0;
          end
        end
        VERIFY: begin
          if (mism) begin
            state <= HUNT;
          end else if (word_end) begin
            if (good_cnt == GW'(LOCK_WORDS - 1)) begin
              state    <= LOCKED;
              locked_q <= 1'b1;
              bad_cnt  <= '0;
              word_bad <= 1'b0;
            end else begin
              good_cnt <= good_cnt + GW'(1);
            end
          end
        end
        LOCKED: begin
          if (word_end) begin
            word_bad <= 1'b0;
            if (word_bad || mism) begin
              if (bad_cnt == BW'(UNLOCK_WORDS - 1)) begin
                state    <= HUNT;
                locked_q <= 1'b0;
              end else begin
                bad_cnt <= bad_cnt + BW'(1);
              end
            end else begin
              bad_cnt <= '0;
            end
          end else if (mism) begin
            word_bad <= 1'b1;
          end
        end
        default: begin
          state    <= HUNT;
          locked_q <= 1'b0;
        end
      endcase

      if (bus.clr_cnt) begin
        bit_cnt_q <= '0;
        err_cnt_q <= '0;
      end else if ((state == LOCKED) && valid) begin
        bit_cnt_q <= sat_inc(bit_cnt_q);
        if (mism)
          err_cnt_q <= sat_inc(err_cnt_q);
      end
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.word_out   = word_out_q;
  assign bus.word_valid = word_valid_q;
  assign bus.bit_cnt    = bit_cnt_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_prbs_code_checker.sv
// Self-checking bench for prbs_code_checker. Two instances share one stimulus
// stream: a 16-bit-counter checker and a 4-bit-counter checker for saturation.
module tb_prbs_code_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic enable;
  logic code_in;
  logic clr_cnt;

  prbs_code_checker_if #(.CNT_W(16)) bus16 ();
  prbs_code_checker_if #(.CNT_W(4))  bus4 ();

  assign bus16.enable  = enable;
  assign bus16.code_in = code_in;
  assign bus16.clr_cnt = clr_cnt;
  assign bus4.enable   = enable;
  assign bus4.code_in  = code_in;
  assign bus4.clr_cnt  = clr_cnt;

  prbs_code_checker #(.LOCK_WORDS(4), .UNLOCK_WORDS(4), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  prbs_code_checker #(.LOCK_WORDS(4), .UNLOCK_WORDS(4), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic [7:0] wq[$];

  // Transmitter reference: current word and bit position within it.
  logic [7:0] tx_word;
  int         tx_pos;

  always @(negedge clk) begin
    if (bus16.err_pulse) pulse_cnt++;
    if (bus16.word_valid) wq.push_back(bus16.word_out);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gold_next(input logic [7:0] w);
    logic fb;
    fb = ^(w & 8'h8E);
    return {w[6:0], fb};
  endfunction

  task automatic tx_restart();
    tx_word = 8'hAA;
    tx_pos  = 0;
  endtask

  task automatic tx_bit(output logic b);
    b = tx_word[7 - tx_pos];
    tx_pos++;
    if (tx_pos == 8) begin
      tx_pos  = 0;
      tx_word = gold_next(tx_word);
    end
  endtask

  task automatic send(input logic flip, input logic with_clr);
    logic b;
    tx_bit(b);
    @(negedge clk);
    enable  = 1'b1;
    code_in = b ^ flip;
    clr_cnt = with_clr;
    @(posedge clk);
    #1;
    enable  = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic gap();
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_gap();
    @(negedge clk);
    enable  = 1'b0;
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    chk("clr_bit_cnt", bus16.bit_cnt, 0);
    chk("clr_err_cnt", bus16.err_cnt, 0);
  endtask

  task automatic send_clean(input int n);
    repeat (n) send(1'b0, 1'b0);
  endtask

  // One word with a single flipped bit at position p (0 = MSB), sent while locked.
  task automatic send_word_err(input int p);
    for (int i = 0; i < 8; i++) begin
      send(i == p, 1'b0);
      if (i == p) chk("err_pulse_next_cycle", bus16.err_pulse, 1);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_locked"},     bus16.locked, 0);
    chk({tag, "_err_pulse"},  bus16.err_pulse, 0);
    chk({tag, "_word_valid"}, bus16.word_valid, 0);
    chk({tag, "_word_out"},   bus16.word_out, 8'h00);
    chk({tag, "_bit_cnt"},    bus16.bit_cnt, 0);
    chk({tag, "_err_cnt"},    bus16.err_cnt, 0);
  endtask

  initial begin
    logic [7:0] expw;
    int p0;
    int q0;
    int n;
    int bad;
    logic early;
    logic dummy;

    rst_n   = 1'b0;
    enable  = 1'b0;
    code_in = 1'b0;
    clr_cnt = 1'b0;
    tx_restart();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean aligned stream: lock exactly at valid bit 40.
    send_clean(39);
    chk("lock_not_before_40", bus16.locked, 0);
    send_clean(1);
    chk("lock_at_40", bus16.locked, 1);
    send_clean(800);
    expw = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      chk("word_seq", wq[i], expw);
      expw = gold_next(expw);
    end
    chk("clean_bit_cnt", bus16.bit_cnt, 800);
    chk("clean_err_cnt", bus16.err_cnt, 0);
    chk("clean_pulses", pulse_cnt, 0);
    chk("sat4_bit_cnt", bus4.bit_cnt, 15);

    // Three isolated single-bit errors: counted, lock kept.
    p0 = pulse_cnt;
    for (int k = 0; k < 3; k++) begin
      send_word_err($urandom_range(0, 7));
      send_clean(16);
    end
    chk("iso_pulses", pulse_cnt - p0, 3);
    chk("iso_err_cnt", bus16.err_cnt, 3);
    chk("iso_bit_cnt", bus16.bit_cnt, 872);
    chk("iso_locked", bus16.locked, 1);

    // Four consecutive bad words drop lock; a clean stream relocks in 40 bits.
    clr_gap();
    for (int k = 0; k < 4; k++) begin
      send_word_err($urandom_range(0, 7));
      if (k == 2) chk("still_locked_3bad", bus16.locked, 1);
    end
    chk("unlock_after_4bad", bus16.locked, 0);
    send_clean(39);
    chk("relock_not_early", bus16.locked, 0);
    send_clean(1);
    chk("relock_at_40", bus16.locked, 1);
    chk("relock_err_cnt_kept", bus16.err_cnt, 4);
    chk("relock_bit_cnt", bus16.bit_cnt, 32);

    // Saturation on the 4-bit counters: 16 errors, never 4 bad words in a row.
    clr_gap();
    for (int g = 0; g < 8; g++) begin
      send_word_err($urandom_range(0, 7));
      send_word_err($urandom_range(0, 7));
      send_clean(8);
    end
    chk("sat_locked", bus16.locked, 1);
    chk("sat_err16", bus16.err_cnt, 16);
    chk("sat_bit16", bus16.bit_cnt, 192);
    chk("sat_err4", bus4.err_cnt, 15);
    chk("sat_bit4", bus4.bit_cnt, 15);

    // Clear coinciding with a counted error bit: clear wins.
    send(1'b1, 1'b1);
    chk("clr_vs_err_err_cnt", bus16.err_cnt, 0);
    chk("clr_vs_err_bit_cnt", bus16.bit_cnt, 0);
    chk("clr_vs_err_err4", bus4.err_cnt, 0);
    chk("clr_vs_err_pulse", bus16.err_pulse, 1);

    // Asynchronous reset mid-word.
    send_clean(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midword_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Error on the last bit of VERIFY word 2: back to HUNT, 40 more bits to lock.
    tx_restart();
    send_clean(23);
    send(1'b1, 1'b0);
    early = bus16.locked;
    for (int i = 0; i < 39; i++) begin
      send(1'b0, 1'b0);
      early = early | bus16.locked;
    end
    chk("verify_err_no_early_lock", early, 0);
    send_clean(1);
    chk("verify_err_relock_40", bus16.locked, 1);

    // Mid-stream start with enable toggling every cycle.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tx_restart();
    repeat ($urandom_range(1, 63)) tx_bit(dummy);
    n = 0;
    while (!bus16.locked && n < 4000) begin
      send(1'b0, 1'b0);
      gap();
      n++;
    end
    chk("midstream_lock", bus16.locked, 1);
    chk("midstream_min_bits", (n >= 40), 1);
    clr_gap();
    q0 = wq.size();
    repeat (160) begin
      send(1'b0, 1'b0);
      gap();
    end
    chk("midstream_bit_cnt", bus16.bit_cnt, 160);
    chk("midstream_err_cnt", bus16.err_cnt, 0);
    bad = 0;
    for (int i = q0 + 1; i < wq.size(); i++)
      if (wq[i] !== gold_next(wq[i-1])) bad++;
    chk("midstream_word_chain", bad, 0);
    chk("midstream_word_count", (wq.size() - q0 >= 19), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
